// File: rtl/song_pkg.sv
// Shared constants, entry layout and FSM states for the song sequencer.
package song_pkg;

  localparam int WAIT_BIT = 15;
  localparam int NOTE_MSB = 14;
  localparam int NOTE_LSB = 9;
  localparam int DUR_MSB  = 8;
  localparam int DUR_LSB  = 3;

  localparam int SONG_LEN  = 32;
  localparam int NUM_SONGS = 4;
  localparam int IDX_W     = $clog2(SONG_LEN);
  localparam int SEL_W     = $clog2(NUM_SONGS);
  localparam int FLD_W     = NOTE_MSB - NOTE_LSB + 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SONG_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_WAIT_BEATS,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic             is_wait;
    logic [FLD_W-1:0] val;
    logic [FLD_W-1:0] dur;
  } entry_t;

  function automatic entry_t decode_entry(input logic [15:3] raw);
    entry_t e;
    e.is_wait = raw[WAIT_BIT];
    e.val     = raw[NOTE_MSB:NOTE_LSB];
    e.dur     = raw[DUR_MSB:DUR_LSB];
    return e;
  endfunction

endpackage

// File: rtl/song_sequencer_voice_alloc.sv
// Lowest-index free voice picker: one-hot grant plus all-busy flag.
module voice_alloc #(
  parameter int N = 3
) (
  input  logic [N-1:0] busy_i,
  output logic [N-1:0] grant_o,
  output logic         none_free_o
);

  // Scan high to low so the lowest free index is the last writer.
  always_comb begin
    grant_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!busy_i[i]) begin
        grant_o    = '0;
        grant_o[i] = 1'b1;
      end
    end
  end

  assign none_free_o = &busy_i;

endmodule

// File: rtl/song_sequencer.sv
// Walks a 32-entry song in ROM, dispatching notes to free voices
// and holding on wait entries for a number of beats.
module song_sequencer
  import song_pkg::*;
#(
  parameter int NUM_VOICES = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  play,
  input  logic [1:0]            song_sel,
  input  logic                  beat,
  output logic [6:0]            rom_addr,
  input  logic [15:0]           rom_dout,
  input  logic [NUM_VOICES-1:0] voice_busy,
  output logic [NUM_VOICES-1:0] voice_load,
  output logic [5:0]            voice_note,
  output logic [5:0]            voice_duration,
  output logic                  playing,
  output logic                  song_done
);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [FLD_W-1:0]        wcnt_q, wcnt_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [NUM_VOICES-1:0]   load_q, load_d;
  logic [FLD_W-1:0]        note_q, note_d;
  logic [FLD_W-1:0]        dur_q, dur_d;
  logic                    playing_q, playing_d;
  logic                    done_q, done_d;

  logic [NUM_VOICES-1:0]   grant;
  logic                    none_free;
  logic                    adv;
  logic                    active;
  entry_t                  ent;
  logic                    unused_rsvd;

  assign ent         = decode_entry(rom_dout[15:3]);
  assign unused_rsvd = ^rom_dout[2:0];
  assign active      = (state_q != ST_IDLE);

  voice_alloc #(
    .N (NUM_VOICES)
  ) u_alloc (
    .busy_i      (voice_busy),
    .grant_o     (grant),
    .none_free_o (none_free)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    sel_d   = sel_q;
    load_d  = '0;
    note_d  = note_q;
    dur_d   = dur_q;
    done_d  = 1'b0;
    adv     = 1'b0;

    if (active && (song_sel != sel_q)) begin
      state_d = ST_FETCH;
      idx_d   = '0;
      wcnt_d  = '0;
      sel_d   = song_sel;
    end else if (active && !play) begin
      state_d = state_q;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (play) begin
            state_d = ST_FETCH;
            sel_d   = song_sel;
            idx_d   = '0;
          end
        end
        ST_FETCH: state_d = ST_DECODE;
        ST_DECODE: begin
          unique case (1'b1)
            ent.is_wait && (ent.val == '0): adv = 1'b1;
            ent.is_wait && (ent.val != '0): begin
              wcnt_d  = ent.val;
              state_d = ST_WAIT_BEATS;
            end
            !ent.is_wait && (ent.val == '0): adv = 1'b1;
            !ent.is_wait && (ent.val != '0): begin
              if (!none_free) begin
                load_d = grant;
                note_d = ent.val;
                dur_d  = ent.dur;
                adv    = 1'b1;
              end
            end
          endcase
        end
        ST_WAIT_BEATS: begin
          if (beat) begin
            wcnt_d = wcnt_q - 1'b1;
            adv    = (wcnt_q == FLD_W'(1));
          end
        end
        ST_DONE: begin
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase

      if (adv) begin
        if (idx_q == IDX_LAST) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_FETCH;
        end
      end
    end

    playing_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      wcnt_q    <= '0;
      sel_q     <= '0;
      load_q    <= '0;
      note_q    <= '0;
      dur_q     <= '0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wcnt_q    <= wcnt_d;
      sel_q     <= sel_d;
      load_q    <= load_d;
      note_q    <= note_d;
      dur_q     <= dur_d;
      playing_q <= playing_d;
      done_q    <= done_d;
    end
  end

  assign rom_addr       = {sel_q, idx_q};
  assign voice_load     = load_q;
  assign voice_note     = note_q;
  assign voice_duration = dur_q;
  assign playing        = playing_q;
  assign song_done      = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: ROM and voice models, decode
// vector table, then multi-cycle sequences.
module tb_song_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        play;
  logic [1:0]  song_sel;
  logic        beat;
  logic [6:0]  rom_addr;
  logic [15:0] rom_dout;
  logic [2:0]  voice_busy;
  logic [2:0]  voice_load;
  logic [5:0]  voice_note;
  logic [5:0]  voice_duration;
  logic        playing;
  logic        song_done;

  logic [15:0] rom [128];
  logic        force_en;
  logic [2:0]  force_busy;
  logic [2:0]  model_busy;
  logic [5:0]  vcnt [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  song_sequencer #(.NUM_VOICES(3)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .play           (play),
    .song_sel       (song_sel),
    .beat           (beat),
    .rom_addr       (rom_addr),
    .rom_dout       (rom_dout),
    .voice_busy     (voice_busy),
    .voice_load     (voice_load),
    .voice_note     (voice_note),
    .voice_duration (voice_duration),
    .playing        (playing),
    .song_done      (song_done)
  );

  always @(posedge clk) rom_dout <= rom[rom_addr];

  always @(posedge clk or negedge reset_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset_n) vcnt[i] <= '0;
      else if (voice_load[i]) vcnt[i] <= 6'd40;
      else if (vcnt[i] != 0) vcnt[i] <= vcnt[i] - 6'd1;
    end
  end

  always_comb begin
    model_busy = '0;
    for (int i = 0; i < 3; i++) model_busy[i] = (vcnt[i] != 0);
  end

  assign voice_busy = force_en ? force_busy : model_busy;

  typedef struct {
    logic [15:0] entry;
    logic [2:0]  busy;
    logic [2:0]  exp_load;
    logic [5:0]  exp_note;
    logic [5:0]  exp_dur;
    logic [6:0]  exp_addr;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  function automatic logic [15:0] mk(input logic w, input logic [5:0] v,
                                     input logic [5:0] d);
    return {w, v, d, 3'b000};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
  endtask

  task automatic apply_reset(input logic [1:0] sel);
    play     = 1'b0;
    beat     = 1'b0;
    song_sel = sel;
    reset_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic pulse_beat();
    beat = 1'b1;
    tick();
    beat = 1'b0;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0] = '{mk(0, 49, 12),            3'b000, 3'b001, 6'd49, 6'd12, 7'd1};
    vecs[1] = '{mk(0, 7, 3),              3'b001, 3'b010, 6'd7,  6'd3,  7'd1};
    vecs[2] = '{mk(0, 63, 63),            3'b011, 3'b100, 6'd63, 6'd63, 7'd1};
    vecs[3] = '{mk(0, 5, 2),              3'b101, 3'b010, 6'd5,  6'd2,  7'd1};
    vecs[4] = '{mk(0, 9, 9),              3'b111, 3'b000, 6'd0,  6'd0,  7'd0};
    vecs[5] = '{mk(0, 0, 5),              3'b000, 3'b000, 6'd0,  6'd0,  7'd1};
    vecs[6] = '{mk(1, 0, 7),              3'b000, 3'b000, 6'd0,  6'd0,  7'd1};
    vecs[7] = '{mk(1, 3, 0),              3'b000, 3'b000, 6'd0,  6'd0,  7'd0};
    vecs[8] = '{mk(0, 20, 4) | 16'h0007, 3'b110, 3'b001, 6'd20, 6'd4,  7'd1};

    force_en   = 1'b0;
    force_busy = 3'b000;
    clear_rom();
    play     = 1'b0;
    beat     = 1'b0;
    song_sel = 2'd0;
    reset_n  = 1'b0;
    #3;
    chk("rst_addr", rom_addr, 0);
    chk("rst_load", voice_load, 0);
    chk("rst_note", voice_note, 0);
    chk("rst_dur", voice_duration, 0);
    chk("rst_playing", playing, 0);
    chk("rst_done", song_done, 0);

    // decode table: one entry at idx 0 under a fixed busy mask
    for (int k = 0; k < NV; k++) begin
      clear_rom();
      rom[0]     = vecs[k].entry;
      force_en   = 1'b1;
      force_busy = vecs[k].busy;
      apply_reset(2'd0);
      chk($sformatf("tbl%0d_idle", k), playing, 0);
      play = 1'b1;
      tick();
      tick();
      tick();
      chk($sformatf("tbl%0d_load", k), voice_load, vecs[k].exp_load);
      chk($sformatf("tbl%0d_note", k), voice_note, vecs[k].exp_note);
      chk($sformatf("tbl%0d_dur", k), voice_duration, vecs[k].exp_dur);
      chk($sformatf("tbl%0d_addr", k), rom_addr, vecs[k].exp_addr);
    end

    // song 0: three notes to successive voices, then a 12-beat wait
    clear_rom();
    rom[0]   = mk(0, 49, 12);
    rom[1]   = mk(0, 1, 12);
    rom[2]   = mk(0, 51, 12);
    rom[3]   = mk(1, 12, 6);
    force_en = 1'b0;
    apply_reset(2'd0);
    play = 1'b1;
    tick();
    chk("seqA_playing", playing, 1);
    chk("seqA_addr0", rom_addr, 0);
    tick();
    tick();
    chk("seqA_load1", voice_load, 3'b001);
    chk("seqA_note1", voice_note, 49);
    chk("seqA_dur1", voice_duration, 12);
    tick();
    chk("seqA_gap", voice_load, 0);
    tick();
    chk("seqA_load2", voice_load, 3'b010);
    chk("seqA_note2", voice_note, 1);
    tick();
    tick();
    chk("seqA_load3", voice_load, 3'b100);
    chk("seqA_note3", voice_note, 51);
    chk("seqA_dur3", voice_duration, 12);
    tick();
    beat = 1'b1;
    tick();
    beat = 1'b0;
    for (int b = 0; b < 11; b++) pulse_beat();
    chk("seqA_wait_hold", rom_addr, 3);
    beat = 1'b1;
    tick();
    beat = 1'b0;
    chk("seqA_wait_adv", rom_addr, 4);

    // all voices busy: stall, then release voice 1
    clear_rom();
    rom[0]     = mk(0, 22, 5);
    force_en   = 1'b1;
    force_busy = 3'b111;
    apply_reset(2'd0);
    play = 1'b1;
    tick();
    tick();
    tick();
    chk("stall_noload", voice_load, 0);
    repeat (4) tick();
    chk("stall_noload2", voice_load, 0);
    chk("stall_addr", rom_addr, 0);
    force_busy = 3'b101;
    tick();
    chk("stall_load", voice_load, 3'b010);
    chk("stall_note", voice_note, 22);
    chk("stall_addr_adv", rom_addr, 1);
    force_en = 1'b0;

    // pause during a 5-beat wait
    clear_rom();
    rom[0] = mk(1, 5, 0);
    apply_reset(2'd0);
    play = 1'b1;
    tick();
    tick();
    tick();
    play = 1'b0;
    for (int b = 0; b < 20; b++) pulse_beat();
    chk("pause_addr", rom_addr, 0);
    chk("pause_playing", playing, 1);
    play = 1'b1;
    for (int b = 0; b < 4; b++) pulse_beat();
    chk("pause_resume4", rom_addr, 0);
    beat = 1'b1;
    play = 1'b0;
    tick();
    beat = 1'b0;
    chk("pause_wins", rom_addr, 0);
    play = 1'b1;
    tick();
    pulse_beat();
    chk("pause_final", rom_addr, 1);

    // last entry wait 0 in song 1: song_done once, back to {1,0}
    clear_rom();
    rom[63] = mk(1, 0, 0);
    apply_reset(2'd1);
    play = 1'b1;
    n = 0;
    while (n < 200) begin
      tick();
      n++;
      if (song_done) break;
    end
    chk("done_latency", n, 66);
    chk("done_playing", playing, 0);
    chk("done_addr", rom_addr, 32);
    tick();
    chk("done_once", song_done, 0);
    chk("done_restart", playing, 1);

    // song change mid-wait at idx 17
    clear_rom();
    rom[17] = mk(1, 40, 0);
    rom[64] = mk(0, 33, 8);
    apply_reset(2'd0);
    play = 1'b1;
    repeat (40) tick();
    chk("sel_wait_addr", rom_addr, 17);
    song_sel = 2'd2;
    tick();
    chk("sel_addr", rom_addr, 64);
    chk("sel_playing", playing, 1);
    tick();
    tick();
    chk("sel_load", voice_load, 3'b001);
    chk("sel_note", voice_note, 33);
    chk("sel_dur", voice_duration, 8);
    chk("sel_addr_adv", rom_addr, 65);

    // reset during a load strobe
    clear_rom();
    rom[0] = mk(0, 10, 4);
    apply_reset(2'd0);
    play = 1'b1;
    tick();
    tick();
    tick();
    chk("rstmid_pre", voice_load, 3'b001);
    reset_n = 1'b0;
    #1;
    chk("rstmid_load", voice_load, 0);
    chk("rstmid_note", voice_note, 0);
    chk("rstmid_dur", voice_duration, 0);
    chk("rstmid_addr", rom_addr, 0);
    chk("rstmid_playing", playing, 0);
    chk("rstmid_done", song_done, 0);
    reset_n = 1'b1;
    play    = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
